// File: rtl/bus_master_ahb_syn.sv
// Single-transfer AHB-Lite initiator.
// Command/response handshake in, SINGLE NONSEQ 32-bit transfers out.
module bus_master_ahb_syn #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                  ahb_clk,
    input  logic                  ahb_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [31:0]           ahb_haddr,
    output logic [2:0]            ahb_hburst,
    output logic                  ahb_hmastlock,
    output logic [3:0]            ahb_hprot,
    output logic [2:0]            ahb_hsize,
    output logic [1:0]            ahb_htrans,
    output logic                  ahb_hwrite,
    output logic [31:0]           ahb_hwdata,
    output logic                  ahb_hsel,
    input  logic                  ahb_hready,
    input  logic                  ahb_hresp,
    input  logic [31:0]           ahb_hrdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [29-ADDR_WIDTH:0] BASE_HI = BASE_ADDR[31:ADDR_WIDTH+2];
    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_NSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           to_hit;
    logic [1:0]     htrans_q, htrans_d;
    logic           hsel_q, hsel_d;
    logic [31:0]    haddr_q, haddr_d;
    logic           hwrite_q, hwrite_d;
    logic [31:0]    hwdata_q, hwdata_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           rvalid_q, rvalid_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rerr_q, rerr_d;
    logic           rto_q, rto_d;

    assign cmd_ready     = (state_q == S_IDLE);
    assign rsp_valid     = rvalid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = rerr_q;
    assign rsp_timeout   = rto_q;
    assign ahb_haddr     = haddr_q;
    assign ahb_hburst    = 3'b000;
    assign ahb_hmastlock = 1'b0;
    assign ahb_hprot     = 4'b0011;
    assign ahb_hsize     = 3'b010;
    assign ahb_htrans    = htrans_q;
    assign ahb_hwrite    = hwrite_q;
    assign ahb_hwdata    = hwdata_q;
    assign ahb_hsel      = hsel_q;

    // Timeout counter saturates; the abort fires on the last allowed stalled cycle.
    assign cnt_inc = (cnt_q == TO_MAX) ? cnt_q : cnt_q + CW'(1);
    assign to_hit  = TO_EN && (cnt_q >= TO_MAX - CW'(1));

    // Next-state and registered-output logic; a completing hready beats the timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        htrans_d = htrans_q;
        hsel_d   = hsel_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rto_d    = rto_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d  = S_ADDR;
                    cnt_d    = '0;
                    htrans_d = HT_NSEQ;
                    hsel_d   = 1'b1;
                    haddr_d  = {BASE_HI, cmd_addr, 2'b00};
                    hwrite_d = cmd_write;
                    wdata_d  = cmd_wdata;
                end
            end
            S_ADDR: begin
                if (ahb_hready) begin
                    state_d  = S_DATA;
                    cnt_d    = cnt_inc;
                    htrans_d = HT_IDLE;
                    hsel_d   = 1'b0;
                    hwdata_d = wdata_q;
                end else if (to_hit) begin
                    state_d  = S_RESP;
                    htrans_d = HT_IDLE;
                    hsel_d   = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rto_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DATA: begin
                if (ahb_hready) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = hwrite_q ? 32'h0 : ahb_hrdata;
                    rerr_d   = ahb_hresp;
                    rto_d    = 1'b0;
                end else if (to_hit) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rto_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ahb_clk) begin
        if (ahb_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            htrans_q <= HT_IDLE;
            hsel_q   <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            rto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            htrans_q <= htrans_d;
            hsel_q   <= hsel_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rto_q    <= rto_d;
        end
    end

endmodule

// File: tb/tb_bus_master_ahb_syn.sv
// Bench for bus_master_ahb_syn: scripted AHB slave with per-transfer
// wait states, latency and response values predicted from transfer rules.
module tb_bus_master_ahb_syn;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'hA000_0000;
    localparam int          TO   = 8;

    logic          clk;
    logic          ahb_reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [31:0]   ahb_haddr;
    logic [2:0]    ahb_hburst;
    logic          ahb_hmastlock;
    logic [3:0]    ahb_hprot;
    logic [2:0]    ahb_hsize;
    logic [1:0]    ahb_htrans;
    logic          ahb_hwrite;
    logic [31:0]   ahb_hwdata;
    logic          ahb_hsel;
    logic          ahb_hready;
    logic          ahb_hresp;
    logic [31:0]   ahb_hrdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;
    logic        last_to    = 1'b0;

    bus_master_ahb_syn #(
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ahb_clk       (clk),
        .ahb_reset     (ahb_reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .ahb_haddr     (ahb_haddr),
        .ahb_hburst    (ahb_hburst),
        .ahb_hmastlock (ahb_hmastlock),
        .ahb_hprot     (ahb_hprot),
        .ahb_hsize     (ahb_hsize),
        .ahb_htrans    (ahb_htrans),
        .ahb_hwrite    (ahb_hwrite),
        .ahb_hwdata    (ahb_hwdata),
        .ahb_hsel      (ahb_hsel),
        .ahb_hready    (ahb_hready),
        .ahb_hresp     (ahb_hresp),
        .ahb_hrdata    (ahb_hrdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // One transfer; waits in ADDR (wa) and DATA (wdw) phases, optional ERROR.
    task automatic xfer(input bit wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input int wa, input int wdw,
                        input bit er, input bit hold);
        int          total;
        int          last;
        int          n;
        bit          tmo;
        bit          in_a;
        logic [31:0] rd;
        logic [31:0] ea;
        rd = $urandom();
        ea = {BASE[31:AW+2], a, 2'b00};
        if (er && wdw == 0) wdw = 1;
        total = 2 + wa + wdw;
        tmo   = (TO > 0) && (total > TO);
        last  = tmo ? TO : total;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = a;
        cmd_wdata  = wd;
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_write = ~wr;
            cmd_addr  = AW'($urandom());
            cmd_wdata = $urandom();
        end else begin
            cmd_valid = 1'b0;
        end
        for (int c = 1; c <= last; c++) begin
            in_a       = (c <= wa + 1);
            ahb_hready = in_a ? (c == wa + 1) : (c == total);
            ahb_hresp  = er && !in_a && (c >= total - 1);
            ahb_hrdata = (c == total) ? rd : $urandom();
            @(negedge clk);
            if (c == 1) begin
                chk("hold_rdata", rsp_rdata, last_rdata);
                chk("hold_err", 32'(rsp_err), 32'(last_err));
                chk("hold_to", 32'(rsp_timeout), 32'(last_to));
            end
            chk("htrans", 32'(ahb_htrans), in_a ? 32'd2 : 32'd0);
            chk("hsel", 32'(ahb_hsel), 32'(in_a));
            if (in_a) begin
                chk("haddr", ahb_haddr, ea);
                chk("hwrite", 32'(ahb_hwrite), 32'(wr));
            end else if (wr) begin
                chk("hwdata", ahb_hwdata, wd);
            end
            chk("busy_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        ahb_hrdata = $urandom();
        @(negedge clk);
        last_rdata = (wr || tmo) ? 32'h0 : rd;
        last_err   = tmo || er;
        last_to    = tmo;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(last_err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(last_to));
        chk("rsp_rdata", rsp_rdata, last_rdata);
        chk("rsp_htrans", 32'(ahb_htrans), 32'd0);
        chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_htrans"}, 32'(ahb_htrans), 32'd0);
        chk({tag, "_hsel"}, 32'(ahb_hsel), 32'd0);
        chk({tag, "_hwrite"}, 32'(ahb_hwrite), 32'd0);
        chk({tag, "_haddr"}, ahb_haddr, 32'd0);
        chk({tag, "_hwdata"}, ahb_hwdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_to"}, 32'(rsp_timeout), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Reset asserted in the second cycle of a stalled read.
    task automatic reset_mid_read();
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 8'h3C;
        ahb_hready = 1'b0;
        ahb_hresp  = 1'b0;
        @(negedge clk);
        chk("rst_accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_c1_htrans", 32'(ahb_htrans), 32'd2);
        @(posedge clk);
        #1;
        ahb_reset = 1'b1;
        @(negedge clk);
        chk("rst_c2_htrans", 32'(ahb_htrans), 32'd2);
        @(posedge clk);
        #1;
        ahb_reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst_mid");
        for (int i = 0; i < 4; i++) begin
            ahb_hready = 1'b1;
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          wr;
        bit          er;
        bit          hold;
        logic [AW-1:0] a;
        logic [31:0] wd;
        int          wa;
        int          wdw;
        ahb_reset  = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        ahb_hrdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        chk("hburst", 32'(ahb_hburst), 32'd0);
        chk("hmastlock", 32'(ahb_hmastlock), 32'd0);
        chk("hprot", 32'(ahb_hprot), 32'd3);
        chk("hsize", 32'(ahb_hsize), 32'd2);
        @(posedge clk);
        #1;
        ahb_reset = 1'b0;

        xfer(1'b1, 8'h05, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        xfer(1'b0, 8'h11, 32'h0, 1, 0, 1'b0, 1'b0);
        xfer(1'b1, 8'h22, 32'hCAFE_F00D, 0, 1, 1'b1, 1'b0);
        xfer(1'b0, 8'h33, 32'h0, 0, 2, 1'b1, 1'b0);
        xfer(1'b0, 8'h44, 32'h0, 20, 0, 1'b0, 1'b0);
        xfer(1'b1, 8'h45, 32'h1111_2222, 1, 20, 1'b0, 1'b0);
        xfer(1'b0, 8'h46, 32'h0, 3, 3, 1'b0, 1'b0);
        xfer(1'b0, 8'h47, 32'h0, 3, 4, 1'b0, 1'b0);
        xfer(1'b0, 8'h48, 32'h0, 6, 0, 1'b0, 1'b0);
        xfer(1'b0, 8'hFF, 32'h0, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            xfer(i[0], AW'(8'h60 + i), $urandom(), i[0] ? 1 : 0,
                 i[0] ? 0 : 1, 1'b0, i != 3);
        end

        reset_mid_read();
        xfer(1'b0, 8'h3C, 32'h0, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = AW'($urandom());
            wd   = $urandom();
            wa   = $urandom_range(0, 4);
            wdw  = $urandom_range(0, 4);
            er   = ($urandom_range(0, 3) == 0);
            hold = (i != 39) && ($urandom_range(0, 1) == 1);
            xfer(wr, a, wd, wa, wdw, er, hold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
